nested_int_ctrl: RTL

- Parametrised interrupt coprocessor: NUM_SRC sources, per-source mask, per-source level/edge capture, fixed priority (highest index wins).
- Nesting: an EPC stack of depth EPC_DEPTH lets a higher-priority source preempt a running handler.
- Sits beside the CPU control unit. The CPU sees a request and source ID, acknowledges entry while pushing the return PC, and signals ERET to pop it.

---
 rtl/nested_int_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/nested_int_ctrl.sv
// nested_int_ctrl: fixed-priority interrupt controller with per-source mask, level/edge capture
// and an EPC stack that lets a higher-priority source preempt a running handler.
module nested_int_ctrl #(
  parameter int                 NUM_SRC   = 3,
  parameter int                 EPC_DEPTH = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b0}},
  parameter int                 ID_W      = $clog2(NUM_SRC+1),
  localparam int                DEPTH_W   = $clog2(EPC_DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic               ie_w_en,
  input  logic               ie_w_data,
  input  logic               mask_w_en,
  input  logic [NUM_SRC-1:0] mask_w_data,
  input  logic               pend_clr_en,
  input  logic [NUM_SRC-1:0] pend_clr_mask,
  input  logic               int_ack,
  input  logic [31:0]        epc_w_data,
  input  logic               eret,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        epc,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] mask,
  output logic               ie,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] ack_vec;
  logic [NUM_SRC-1:0] eret_vec;
  logic [31:0]        stack_q [EPC_DEPTH];
  logic [ID_W-1:0]    cur_id;
  logic               ack_ok;
  logic               eret_ok;
  logic               proto_err;

  // Later loop iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    int_id = '0;
    cur_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && mask[i]) int_id = ID_W'(i+1);
      if (in_service[i])         cur_id = ID_W'(i+1);
    end
  end

  assign int_req = ie && (int_id != '0) && (int_id > cur_id) &&
                   (depth < DEPTH_W'(EPC_DEPTH));

  always_comb begin
    epc = '0;
    for (int i = 0; i < EPC_DEPTH; i++) begin
      if (depth == DEPTH_W'(i+1)) epc = stack_q[i];
    end
  end

  always_comb begin
    set_vec  = '0;
    ack_vec  = '0;
    eret_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      set_vec[i]  = EDGE_MASK[i] ? (int_src[i] & ~edge_q[i]) : int_src[i];
      ack_vec[i]  = (int_id == ID_W'(i+1));
      eret_vec[i] = (cur_id == ID_W'(i+1));
    end
  end

  assign ack_ok    = int_ack & ~eret & int_req;
  assign eret_ok   = eret & ~int_ack & (depth != '0);
  assign proto_err = (int_ack & eret) | (int_ack & ~int_req) | (eret & (depth == '0));
  // A new capture is OR-ed in after clearing, so set beats clear on the same bit.
  assign clr_vec   = (pend_clr_en ? pend_clr_mask : '0) | (ack_ok ? ack_vec : '0);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q     <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
      ie         <= 1'b0;
      depth      <= '0;
      err        <= 1'b0;
      for (int i = 0; i < EPC_DEPTH; i++) stack_q[i] <= '0;
    end else if (en) begin
      edge_q  <= int_src;
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_w_en) mask <= mask_w_data;
      if (ie_w_en)     ie <= ie_w_data;
      else if (ack_ok) ie <= 1'b0;
      if (proto_err) err <= 1'b1;
      if (ack_ok) begin
        in_service <= in_service | ack_vec;
        depth      <= depth + DEPTH_W'(1);
        for (int i = 0; i < EPC_DEPTH; i++) begin
          if (depth == DEPTH_W'(i)) stack_q[i] <= epc_w_data;
        end
      end else if (eret_ok) begin
        in_service <= in_service & ~eret_vec;
        depth      <= depth - DEPTH_W'(1);
      end
    end
  end

endmodule
